pocket_detector: RTL and testbench
==================================

Name: pocket_detector

Overview:
- Consumer of the hole-drawing interface (holeNumber / drawingRequestHoles) and the ball-drawing interface.
- Counts, per ball and per frame, the pixels where a ball and a hole draw at the same time.
- At each frame boundary, a ball that overlapped a hole by at least OVERLAP_THRESHOLD pixels is declared pocketed.
- Each pocketing is queued as a {ball, hole} event behind a valid/ready handshake for game logic (scoring, ball removal).

Parameters:
- NUM_BALLS, 16: number of balls tracked; ballNumber range 0..NUM_BALLS-1.
- OVERLAP_THRESHOLD, 64: minimum overlapping pixels per frame to declare a pocket.
- FIFO_DEPTH, 4: event queue entries (power of 2).

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse in vertical blanking.
- drawingRequestBall  in  1  a ball pixel is being drawn.
- ballNumber  in  4  index of the ball drawing; valid when drawingRequestBall=1.
- drawingRequestHoles  in  1  a hole pixel is being drawn.
- holeNumber  in  3  hole index 1..6; 0 = none.
- clearBall  in  1  one-cycle pulse; un-pocket ball clearIndex.
- clearIndex  in  4  ball to un-pocket.
- eventReady  in  1  consumer accepts the head event.
- eventValid  out  1  queue non-empty.
- eventBall  out  4  ball index of the head event.
- eventHole  out  3  hole index of the head event.
- pocketedMask  out  NUM_BALLS  bit i = ball i pocketed.
- overflow  out  1  sticky; an event was dropped because the queue was full.
- busy  out  1  high while in SCAN.

Behaviour:
- Reset (resetN=0 at a clk edge): all outputs 0; all counters, hole latches, pocketedMask and queue cleared; state = ACCUM. Reset mid-SCAN aborts the scan.
- Overlap hit: a cycle in ACCUM with drawingRequestBall=1, drawingRequestHoles=1, holeNumber!=0, ballNumber<NUM_BALLS, and pocketedMask[ballNumber]=0.
- Cycle alignment of the two request streams is the upstream's responsibility.
- On a hit:
  - cnt[ballNumber] increments, saturating at 1023 (10-bit).
  - If hole[ballNumber]==0, hole[ballNumber] is set to holeNumber (first hole touched wins). Later hits on other holes leave the latch unchanged.
- States:
  - ACCUM: accumulate hits. startOfFrame -> SCAN with idx=0.
  - SCAN: one ball per cycle, idx = 0..NUM_BALLS-1. Pixel inputs and startOfFrame are ignored. After idx=NUM_BALLS-1 -> ACCUM. busy=1.
- Per scanned ball i:
  - If cnt[i]>=OVERLAP_THRESHOLD and pocketedMask[i]=0:
    - Queue not full: push {i, hole[i]} and set pocketedMask[i] on the next edge.
    - Queue full: drop the event, set overflow, leave pocketedMask[i]=0 so the ball is re-detected next frame.
  - cnt[i] and hole[i] are cleared in the same cycle regardless of outcome.
- Scan latency: startOfFrame to the last possible push = NUM_BALLS+1 cycles. The first event is visible on eventValid 2 cycles after startOfFrame (ball 0 qualifying).
- Queue:
  - FWFT; eventBall/eventHole always show the head entry; 0 when empty.
  - Pop when eventValid && eventReady.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged, including when full (a push while full with a simultaneous pop succeeds).
  - Pointers wrap modulo FIFO_DEPTH.
- clearBall:
  - Clears pocketedMask[clearIndex] on the next edge; ignored if clearIndex>=NUM_BALLS.
  - If it coincides with a SCAN set of the same bit, clear wins.
- overflow is cleared only by reset.

Test Plan:
- Reset, then 64 hit cycles (ball 3, hole 2) and a startOfFrame pulse -> 2 cycles later eventValid=1, eventBall=3, eventHole=2, pocketedMask=0x0008; eventReady=1 for 1 cycle -> eventValid=0.
- 63 hit cycles on ball 5, then startOfFrame -> no event, mask=0; the next frame starts with cnt[5]=0.
- Ball 1 hits hole 4 for 10 cycles, then hole 6 for 60 cycles, then startOfFrame -> event {1,4}.
- eventReady=0; balls 0..5 each qualify in one frame -> 4 events queued in index order 0..3, overflow=1, mask=0x000F. Pop all 4 and repeat the overlap for balls 4..5 next frame -> events {4,x},{5,x}.
- Ball 2 pocketed, then 100 further hits on ball 2 -> no new event. clearBall with clearIndex=2 -> mask bit 2 = 0; a re-overlap produces a new event.
- Assert resetN=0 in the third SCAN cycle with 2 events queued -> on the next edge eventValid=0, busy=0, mask=0, overflow=0.

Source files
------------

// File: rtl/pocket_detector.sv
`default_nettype none
// ============================================================================
// pocket_detector : per-frame ball/hole overlap counter with pocket event queue
// Revision: 1.0
// ============================================================================

module pocket_detector #(
  parameter int NUM_BALLS         = 16,
  parameter int OVERLAP_THRESHOLD = 64,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 drawingRequestBall,
  input  logic [3:0]           ballNumber,
  input  logic                 drawingRequestHoles,
  input  logic [2:0]           holeNumber,
  input  logic                 clearBall,
  input  logic [3:0]           clearIndex,
  input  logic                 eventReady,
  output logic                 eventValid,
  output logic [3:0]           eventBall,
  output logic [2:0]           eventHole,
  output logic [NUM_BALLS-1:0] pocketedMask,
  output logic                 overflow,
  output logic                 busy
);

  localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [9:0]       CNT_MAX   = 10'd1023;
  localparam logic [9:0]       THRESH    = 10'(OVERLAP_THRESHOLD);
  localparam logic [3:0]       LAST_IDX  = 4'(NUM_BALLS - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [9:0]           cnt_q  [NUM_BALLS];
  logic [9:0]           cnt_d  [NUM_BALLS];
  logic [2:0]           hole_q [NUM_BALLS];
  logic [2:0]           hole_d [NUM_BALLS];
  logic [NUM_BALLS-1:0] mask_q, mask_d;
  logic                 ovf_q, ovf_d;

  logic [3:0]           fifo_ball_q [FIFO_DEPTH];
  logic [3:0]           fifo_ball_d [FIFO_DEPTH];
  logic [2:0]           fifo_hole_q [FIFO_DEPTH];
  logic [2:0]           fifo_hole_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;

  logic                 hit;
  logic                 pop;
  logic                 push;
  logic                 full;
  logic                 qualifies;

  assign full = (count_q == FIFO_FULL);
  assign pop  = (count_q != '0) && eventReady;

  // Pixel inputs only count while accumulating; already-pocketed balls are ignored.
  assign hit = (state_q == ST_ACCUM) && drawingRequestBall && drawingRequestHoles &&
               (holeNumber != 3'd0) && ({28'd0, ballNumber} < 32'(NUM_BALLS)) &&
               !mask_q[ballNumber];

  assign qualifies = (state_q == ST_SCAN) && (cnt_q[idx_q] >= THRESH) && !mask_q[idx_q];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    hole_d      = hole_q;
    mask_d      = mask_q;
    ovf_d       = ovf_q;
    fifo_ball_d = fifo_ball_q;
    fifo_hole_d = fifo_hole_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    push        = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        if (hit) begin
          if (cnt_q[ballNumber] != CNT_MAX) begin
            cnt_d[ballNumber] = cnt_q[ballNumber] + 10'd1;
          end
          if (hole_q[ballNumber] == 3'd0) begin
            hole_d[ballNumber] = holeNumber;
          end
        end
        if (startOfFrame) begin
          state_d = ST_SCAN;
          idx_d   = 4'd0;
        end
      end

      ST_SCAN: begin
        // A simultaneous pop frees a slot, so a full queue can still accept.
        if (qualifies) begin
          if (!full || pop) begin
            push          = 1'b1;
            mask_d[idx_q] = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        cnt_d[idx_q]  = 10'd0;
        hole_d[idx_q] = 3'd0;
        if (idx_q == LAST_IDX) begin
          state_d = ST_ACCUM;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase

    if (push) begin
      fifo_ball_d[wr_ptr_q] = idx_q;
      fifo_hole_d[wr_ptr_q] = hole_q[idx_q];
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    // Clear is applied last so it overrides a same-cycle pocket set.
    if (clearBall && ({28'd0, clearIndex} < 32'(NUM_BALLS))) begin
      mask_d[clearIndex] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= ST_ACCUM;
      idx_q    <= 4'd0;
      mask_q   <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        cnt_q[i]  <= 10'd0;
        hole_q[i] <= 3'd0;
      end
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        fifo_ball_q[j] <= 4'd0;
        fifo_hole_q[j] <= 3'd0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      hole_q      <= hole_d;
      mask_q      <= mask_d;
      ovf_q       <= ovf_d;
      fifo_ball_q <= fifo_ball_d;
      fifo_hole_q <= fifo_hole_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign eventValid   = (count_q != '0);
  assign eventBall    = eventValid ? fifo_ball_q[rd_ptr_q] : 4'd0;
  assign eventHole    = eventValid ? fifo_hole_q[rd_ptr_q] : 3'd0;
  assign pocketedMask = mask_q;
  assign overflow     = ovf_q;
  assign busy         = (state_q == ST_SCAN);

endmodule

`default_nettype wire

// File: tb/tb_pocket_detector.sv
`default_nettype none
// tb_pocket_detector : directed + randomized checks against a frame-level
// pocket model (per-ball counts, first-hole latch, bounded event queue).

module tb_pocket_detector;

  localparam int NB = 16;
  localparam int TH = 64;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          resetN;
  logic          startOfFrame;
  logic          drawingRequestBall;
  logic [3:0]    ballNumber;
  logic          drawingRequestHoles;
  logic [2:0]    holeNumber;
  logic          clearBall;
  logic [3:0]    clearIndex;
  logic          eventReady;
  logic          eventValid;
  logic [3:0]    eventBall;
  logic [2:0]    eventHole;
  logic [NB-1:0] pocketedMask;
  logic          overflow;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  int            m_cnt  [NB];
  int            m_hole [NB];
  logic [NB-1:0] m_mask;
  logic          m_ovf;
  int            mq_ball [$];
  int            mq_hole [$];

  pocket_detector #(
    .NUM_BALLS(NB),
    .OVERLAP_THRESHOLD(TH),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .drawingRequestBall(drawingRequestBall),
    .ballNumber(ballNumber),
    .drawingRequestHoles(drawingRequestHoles),
    .holeNumber(holeNumber),
    .clearBall(clearBall),
    .clearIndex(clearIndex),
    .eventReady(eventReady),
    .eventValid(eventValid),
    .eventBall(eventBall),
    .eventHole(eventHole),
    .pocketedMask(pocketedMask),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    startOfFrame        = 1'b0;
    drawingRequestBall  = 1'b0;
    ballNumber          = 4'd0;
    drawingRequestHoles = 1'b0;
    holeNumber          = 3'd0;
    clearBall           = 1'b0;
    clearIndex          = 4'd0;
    eventReady          = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_cnt[i]  = 0;
      m_hole[i] = 0;
    end
    m_mask = '0;
    m_ovf  = 1'b0;
    mq_ball.delete();
    mq_hole.delete();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".mask"},  32'(pocketedMask), 32'(m_mask));
    check({tag, ".ovf"},   32'(overflow),     32'(m_ovf));
    check({tag, ".valid"}, 32'(eventValid),   32'(mq_ball.size() > 0));
    check({tag, ".ball"},  32'(eventBall),    (mq_ball.size() > 0) ? 32'(mq_ball[0]) : 32'd0);
    check({tag, ".hole"},  32'(eventHole),    (mq_hole.size() > 0) ? 32'(mq_hole[0]) : 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    model_reset();
    check_outputs("reset");
    check("reset.busy", 32'(busy), 32'd0);
  endtask

  // One accumulation cycle: drive pixel/clear inputs and apply the hit rule.
  task automatic pix(input int b, input int h, input bit rb, input bit rh,
                     input bit clr, input int ci);
    drawingRequestBall  = rb;
    ballNumber          = 4'(b);
    drawingRequestHoles = rh;
    holeNumber          = 3'(h);
    clearBall           = clr;
    clearIndex          = 4'(ci);
    if (rb && rh && h != 0 && b < NB && !m_mask[b]) begin
      if (m_cnt[b] < 1023) m_cnt[b]++;
      if (m_hole[b] == 0) m_hole[b] = h;
    end
    if (clr && ci < NB) m_mask[ci] = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic hits(input int b, input int h, input int n);
    repeat (n) pix(b, h, 1'b1, 1'b1, 1'b0, 0);
  endtask

  // Frame boundary with no pops: evaluate every ball, then wait out the scan.
  task automatic run_frame(input string tag);
    int  pre;
    bit  b0q;
    pre = mq_ball.size();
    b0q = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (m_cnt[i] >= TH && !m_mask[i]) begin
        if (mq_ball.size() < FD) begin
          mq_ball.push_back(i);
          mq_hole.push_back(m_hole[i]);
          m_mask[i] = 1'b1;
          if (i == 0) b0q = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_cnt[i]  = 0;
      m_hole[i] = 0;
    end
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check({tag, ".busy_on"},  32'(busy),       32'd1);
    check({tag, ".valid_t1"}, 32'(eventValid), 32'(pre > 0));
    tick();
    check({tag, ".valid_t2"}, 32'(eventValid), 32'(pre > 0 || b0q));
    repeat (NB - 1) tick();
    check({tag, ".busy_off"}, 32'(busy), 32'd0);
    check_outputs(tag);
  endtask

  task automatic drain(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      eventReady = 1'b1;
      check({tag, ".valid"}, 32'(eventValid), 32'(mq_ball.size() > 0));
      if (mq_ball.size() > 0) begin
        check({tag, ".ball"}, 32'(eventBall), 32'(mq_ball[0]));
        check({tag, ".hole"}, 32'(eventHole), 32'(mq_hole[0]));
      end
      tick();
      if (mq_ball.size() > 0) begin
        void'(mq_ball.pop_front());
        void'(mq_hole.pop_front());
      end
    end
    eventReady = 1'b0;
  endtask

  initial begin
    int tgt [2];
    int len;
    idle_inputs();
    resetN = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Basic pocket: ball 3 in hole 2.
    hits(3, 2, 64);
    run_frame("basic");
    check("basic.exp_mask", 32'(pocketedMask), 32'h0008);
    drain("basic_pop", 1);
    check("basic.empty", 32'(eventValid), 32'd0);

    // One pixel short of the threshold, then counts restart next frame.
    hits(5, 3, 63);
    run_frame("short");
    hits(5, 3, 1);
    run_frame("short2");

    // First hole touched is the one reported.
    hits(1, 4, 10);
    hits(1, 6, 60);
    run_frame("first_hole");
    check("first_hole.h", 32'(eventHole), 32'd4);
    drain("first_hole_pop", 1);

    // Queue overflow, then the dropped balls re-detect.
    do_reset();
    for (int b = 0; b < 6; b++) hits(b, (b % 6) + 1, 64);
    run_frame("ovf");
    check("ovf.exp_mask", 32'(pocketedMask), 32'h000F);
    drain("ovf_pop", 4);
    for (int b = 4; b < 6; b++) hits(b, 5, 64);
    run_frame("redetect");
    drain("redetect_pop", 3);

    // Pocketed ball ignores hits until cleared.
    hits(2, 1, 100);
    run_frame("ignored");
    pix(0, 0, 1'b0, 1'b0, 1'b1, 2);
    check_outputs("cleared");
    hits(2, 3, 70);
    run_frame("repocket");
    drain("repocket_pop", 2);

    // Saturating counter: far more than 1023 hits must still pocket.
    hits(9, 1, 1100);
    run_frame("sat");
    drain("sat_pop", 1);

    // Reset in the middle of a scan with events queued.
    do_reset();
    hits(6, 2, 64);
    hits(7, 3, 64);
    run_frame("pre_abort");
    hits(8, 4, 64);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    model_reset();
    check_outputs("abort");
    check("abort.busy", 32'(busy), 32'd0);
    hits(8, 4, 10);
    run_frame("post_abort");

    // Randomized frames with random clears and partial drains.
    for (int f = 0; f < 25; f++) begin
      tgt[0] = $urandom_range(0, NB - 1);
      tgt[1] = $urandom_range(0, NB - 1);
      len    = $urandom_range(200, 400);
      for (int c = 0; c < len; c++) begin
        int  b;
        bit  clr;
        b   = ($urandom_range(0, 9) != 0) ? tgt[$urandom_range(0, 1)] : $urandom_range(0, NB - 1);
        clr = ($urandom_range(0, 99) < 3);
        pix(b, $urandom_range(0, 6), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
            clr, $urandom_range(0, NB - 1));
      end
      run_frame("rand");
      drain("rand_pop", $urandom_range(0, 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
